// File: rtl/csa_resolve_pkg.sv
// Shared types and helpers for the carry-save resolver.
package csa_resolve_pkg;

   // Controller states: waiting for operands, resolving digits, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width; never narrower than one bit so K == 1 still elaborates.
   function automatic int cnt_width(input int k);
      return (k <= 1) ? 1 : $clog2(k);
   endfunction

endpackage

// File: rtl/csa_resolve_if.sv
// Operand/result handshake bundle for csa_resolve.
// master = producer of operands and consumer of results; slave = the resolver.
interface csa_resolve_if #(
   parameter int N = 256
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_sum;
   logic [N-1:0] in_carry;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_value;
   logic         out_cout;

   modport master (
      output in_valid, in_sum, in_carry, in_sub, out_ready,
      input  in_ready, out_valid, out_value, out_cout
   );

   modport slave (
      input  in_valid, in_sum, in_carry, in_sub, out_ready,
      output in_ready, out_valid, out_value, out_cout
   );
endinterface

// File: rtl/cla_add.sv
// N-bit carry-lookahead adder (Kogge-Stone prefix) with carry in and carry out.
module cla_add #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int L = $clog2(N);

   logic [N-1:0] p0;
   logic [N-1:0] gg;
   logic [N-1:0] pp;
   logic [N-1:0] c;

   // Prefix tree: gg[i] ends up as the carry out of bit i, with cin folded into bit 0.
   // NOTE: blocking assignments here are deliberate; each prefix level reads the
   // previous level's values within the same evaluation, like wires in sequence.
   always_comb begin
      p0    = a ^ b;
      gg    = a & b;
      pp    = p0;
      gg[0] = gg[0] | (p0[0] & cin);
      for (int l = 0; l < L; l++) begin
         // Walk downward so gg/pp[i - 2^l] still hold the previous level.
         for (int i = N - 1; i >= (1 << l); i--) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      c    = (gg << 1) | N'(cin);
      sum  = p0 ^ c;
      cout = gg[N-1];
   end

endmodule

// File: rtl/csa_resolve.sv
// Resolves a carry-save (sum, carry) pair to plain binary, W bits per cycle,
// least significant digit first. Subtract mode adds ~carry with carry-in 1.
module csa_resolve
   import csa_resolve_pkg::*;
#(
   parameter int N = 256,
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   csa_resolve_if.slave   bus
);

   localparam int K  = N / W;
   localparam int CW = cnt_width(K);

   generate
      if (N % W != 0) begin : g_bad_width
         $error("csa_resolve: N must be a multiple of W");
      end
   endgenerate

   state_t         state_q;
   state_t         state_d;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [N-1:0]   res_q;
   logic [N-1:0]   res_next;
   logic [N-1:0]   value_q;
   logic           cy_q;
   logic           cout_q;
   logic [W-1:0]   dsum;
   logic           dcout;
   logic           accept;
   logic           last;

   // One digit of the resolution: low W bits of A and B plus the running carry.
   cla_add #(.N(W)) u_digit (
      .a    (a_q[W-1:0]),
      .b    (b_q[W-1:0]),
      .cin  (cy_q),
      .sum  (dsum),
      .cout (dcout)
   );

   assign accept   = (state_q == IDLE) && bus.in_valid;
   assign last     = (state_q == RUN) && (cnt_q == CW'(K - 1));
   // New digit enters at the top; after K digits the result is fully aligned.
   assign res_next = N'({dsum, res_q} >> W);

   assign bus.out_value = value_q;
   assign bus.out_cout  = cout_q;

   // State register; reset lands in IDLE so in_ready is high while rst is held.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs, decoded from the current state only.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand shift registers, digit carry, partial result and published result.
   // NOTE: the wide shift registers are reset too; they are plain flops, not a
   // RAM, and a clean reset keeps an aborted operation from leaking into the next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         value_q <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.in_sum;
         b_q   <= bus.in_sub ? ~bus.in_carry : bus.in_carry;
         cy_q  <= bus.in_sub;
         res_q <= '0;
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         a_q   <= a_q >> W;
         b_q   <= b_q >> W;
         cy_q  <= dcout;
         res_q <= res_next;
         cnt_q <= cnt_q + 1'b1;
         // Publish only on the final digit so partial sums are never visible.
         if (last) begin
            value_q <= res_next;
            cout_q  <= dcout;
         end
      end
   end

endmodule
